// File: rtl/uart_pkg.sv
// Shared UART constants, frame format and receiver state encoding.
// Both the transmitter and the receiver can import this package.
package uart_pkg;

  localparam int BASE_FREQ      = 50_000_000;
  localparam int BAUD_RATE      = 115_200;
  localparam int COUNTS_PER_BIT = BASE_FREQ / BAUD_RATE;
  localparam int HALF_BIT       = COUNTS_PER_BIT / 2;

  localparam int DATA_BITS   = 8;
  localparam bit PARITY_EVEN = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_t;

  // Expected parity bit for a data byte.
  // An odd-parity build would invert the XOR.
  function automatic logic parityOf(input logic [DATA_BITS-1:0] data);
    return (^data) ^ ~PARITY_EVEN;
  endfunction

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for an asynchronous input.
// The reset value is configurable and defaults to the idle-high level.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, even parity, 1 stop bit, with a one-cycle valid pulse.
// Optional macro UART_RX_MAJORITY_EN enables 2-of-3 majority sampling of every bit.
module uart_rx
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic       busy
);

  logic w_rxS;
  logic w_bitVal;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (serial_in),
    .o_sync  (w_rxS)
  );

`ifdef UART_RX_MAJORITY_EN
  // Decisions happen one count late so the sample after nominal is available too.
  localparam logic [15:0] SAMPLE_OFF = 16'd1;
  logic [1:0] r_hist;

  always_ff @(posedge clk) begin
    if (!rst) r_hist <= 2'b11;
    else      r_hist <= {r_hist[0], w_rxS};
  end

  assign w_bitVal = majority3({r_hist, w_rxS});
`else
  localparam logic [15:0] SAMPLE_OFF = 16'd0;
  assign w_bitVal = w_rxS;
`endif

  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1) + SAMPLE_OFF;
  localparam logic [15:0] BIT_LAST  = 16'(COUNTS_PER_BIT - 1) + SAMPLE_OFF;

  rx_state_t   r_state,    w_stateNext;
  logic [15:0] r_count,    w_countNext;
  logic [2:0]  r_bitIndex, w_bitIndexNext;
  logic [7:0]  r_shift,    w_shiftNext;
  logic        r_parBit,   w_parBitNext;
  logic        r_stopBit,  w_stopBitNext;
  logic        r_stopSeen, w_stopSeenNext;
  logic [7:0]  r_data,     w_dataNext;
  logic        r_valid,    w_validNext;
  logic        r_parErr,   w_parErrNext;
  logic        r_frameErr, w_frameErrNext;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= RX_IDLE;
      r_count    <= '0;
      r_bitIndex <= '0;
      r_shift    <= '0;
      r_parBit   <= 1'b0;
      r_stopBit  <= 1'b1;
      r_stopSeen <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_parErr   <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_count    <= w_countNext;
      r_bitIndex <= w_bitIndexNext;
      r_shift    <= w_shiftNext;
      r_parBit   <= w_parBitNext;
      r_stopBit  <= w_stopBitNext;
      r_stopSeen <= w_stopSeenNext;
      r_data     <= w_dataNext;
      r_valid    <= w_validNext;
      r_parErr   <= w_parErrNext;
      r_frameErr <= w_frameErrNext;
    end
  end

  // After a sample the count restarts at SAMPLE_OFF, keeping samples exactly one bit apart.
  always_comb begin
    w_stateNext    = r_state;
    w_countNext    = r_count + 16'd1;
    w_bitIndexNext = r_bitIndex;
    w_shiftNext    = r_shift;
    w_parBitNext   = r_parBit;
    w_stopBitNext  = r_stopBit;
    w_stopSeenNext = 1'b0;
    w_dataNext     = r_data;
    w_validNext    = 1'b0;
    w_parErrNext   = r_parErr;
    w_frameErrNext = r_frameErr;

    case (r_state)
      RX_IDLE: begin
        w_countNext = '0;
        if (!w_rxS) w_stateNext = RX_START;
      end
      RX_START: begin
        if (r_count == HALF_LAST) begin
          w_countNext    = SAMPLE_OFF;
          w_bitIndexNext = '0;
          w_stateNext    = w_bitVal ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_count == BIT_LAST) begin
          w_countNext              = SAMPLE_OFF;
          w_shiftNext[r_bitIndex] = w_bitVal;
          if (r_bitIndex == 3'd7) w_stateNext    = RX_PARITY;
          else                    w_bitIndexNext = r_bitIndex + 3'd1;
        end
      end
      RX_PARITY: begin
        if (r_count == BIT_LAST) begin
          w_countNext  = SAMPLE_OFF;
          w_parBitNext = w_bitVal;
          w_stateNext  = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_stopSeen) begin
          w_dataNext     = r_shift;
          w_validNext    = 1'b1;
          w_parErrNext   = (parityOf(r_shift) != r_parBit);
          w_frameErrNext = !r_stopBit;
          w_stateNext    = r_stopBit ? RX_IDLE : RX_BREAK;
        end else if (r_count == BIT_LAST) begin
          w_stopBitNext  = w_bitVal;
          w_stopSeenNext = 1'b1;
        end
      end
      RX_BREAK: begin
        w_countNext = '0;
        if (w_rxS) w_stateNext = RX_IDLE;
      end
      default: w_stateNext = RX_IDLE;
    endcase
  end

  assign data_out     = r_data;
  assign data_valid   = r_valid;
  assign parity_error = r_parErr;
  assign frame_error  = r_frameErr;
  assign busy         = (r_state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx; each scenario task checks its own results.
// Latency expectations follow UART_RX_MAJORITY_EN when the bench is built with it.
module tb_uart_rx;
  import uart_pkg::*;

`ifdef UART_RX_MAJORITY_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif
  localparam int VALID_LATENCY = 3 + HALF_BIT + 10 * COUNTS_PER_BIT + 1 + OFF;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serial_in = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       frame_error;
  logic       busy;

  uart_rx dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int frameStart = 0;

  always @(posedge clk) cycle++;

  // Record every valid pulse seen half a cycle after the active edge.
  int         validCount = 0;
  int         runLen = 0;
  int         maxRun = 0;
  int         lastValidCycle = 0;
  logic [7:0] lastData = 8'h00;
  logic [7:0] prevData = 8'h00;
  logic       lastPe = 1'b0;
  logic       lastFe = 1'b0;

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      validCount++;
      runLen++;
      if (runLen > maxRun) maxRun = runLen;
      prevData = lastData;
      lastData = data_out;
      lastPe = parity_error;
      lastFe = frame_error;
      lastValidCycle = cycle;
    end else begin
      runLen = 0;
    end
  end

  task automatic sendFrame(input logic [7:0] data, input logic par, input logic stop);
    logic [10:0] bits;
    bits = {stop, par, data, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      serial_in = bits[i];
      if (i == 0) frameStart = cycle;
      repeat (COUNTS_PER_BIT - 1) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    serial_in = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got %h expected 00", data_out); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", data_valid); end
    checks++; if (parity_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_pe got %b expected 0", parity_error); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_fe got %b expected 0", frame_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    rst = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_basic;
    int v0;
    v0 = validCount;
    sendFrame(8'h55, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (validCount !== v0 + 1) begin errors++; $display("[TB] FAIL basic_count got %0d expected %0d", validCount, v0 + 1); end
    checks++; if (lastData !== 8'h55) begin errors++; $display("[TB] FAIL basic_data got %h expected 55", lastData); end
    checks++; if (lastPe !== 1'b0) begin errors++; $display("[TB] FAIL basic_pe got %b expected 0", lastPe); end
    checks++; if (lastFe !== 1'b0) begin errors++; $display("[TB] FAIL basic_fe got %b expected 0", lastFe); end
    checks++; if (maxRun !== 1) begin errors++; $display("[TB] FAIL basic_pulse_width got %0d expected 1", maxRun); end
    checks++; if (lastValidCycle - frameStart !== VALID_LATENCY) begin errors++; $display("[TB] FAIL basic_latency got %0d expected %0d", lastValidCycle - frameStart, VALID_LATENCY); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy got %b expected 0", busy); end
    checks++; if (data_out !== 8'h55) begin errors++; $display("[TB] FAIL basic_data_hold got %h expected 55", data_out); end
  endtask

  task automatic test_parity;
    int v0;
    v0 = validCount;
    sendFrame(8'hA7, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (validCount !== v0 + 1) begin errors++; $display("[TB] FAIL parity_count got %0d expected %0d", validCount, v0 + 1); end
    checks++; if (lastData !== 8'hA7) begin errors++; $display("[TB] FAIL parity_data got %h expected a7", lastData); end
    checks++; if (lastPe !== 1'b1) begin errors++; $display("[TB] FAIL parity_pe got %b expected 1", lastPe); end
    checks++; if (lastFe !== 1'b0) begin errors++; $display("[TB] FAIL parity_fe got %b expected 0", lastFe); end
    repeat (200) @(negedge clk);
    checks++; if (parity_error !== 1'b1) begin errors++; $display("[TB] FAIL parity_pe_hold got %b expected 1", parity_error); end
  endtask

  task automatic test_break;
    int v0;
    v0 = validCount;
    sendFrame(8'h3C, 1'b0, 1'b0);
    repeat (2000) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL break_busy_low got %b expected 1", busy); end
    checks++; if (validCount !== v0 + 1) begin errors++; $display("[TB] FAIL break_count got %0d expected %0d", validCount, v0 + 1); end
    checks++; if (lastData !== 8'h3C) begin errors++; $display("[TB] FAIL break_data got %h expected 3c", lastData); end
    checks++; if (lastFe !== 1'b1) begin errors++; $display("[TB] FAIL break_fe got %b expected 1", lastFe); end
    checks++; if (lastPe !== 1'b0) begin errors++; $display("[TB] FAIL break_pe got %b expected 0", lastPe); end
    serial_in = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL break_busy_release got %b expected 0", busy); end
    repeat (2 * COUNTS_PER_BIT) @(negedge clk);
    checks++; if (validCount !== v0 + 1) begin errors++; $display("[TB] FAIL break_no_extra got %0d expected %0d", validCount, v0 + 1); end
    checks++; if (frame_error !== 1'b1) begin errors++; $display("[TB] FAIL break_fe_hold got %b expected 1", frame_error); end
  endtask

  task automatic test_glitch;
    int v0;
    v0 = validCount;
    @(negedge clk);
    serial_in = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL glitch_busy_high got %b expected 1", busy); end
    repeat (90) @(negedge clk);
    serial_in = 1'b1;
    repeat (3 + HALF_BIT + 1 + OFF - 100) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy_low got %b expected 0", busy); end
    repeat (COUNTS_PER_BIT) @(negedge clk);
    checks++; if (validCount !== v0) begin errors++; $display("[TB] FAIL glitch_no_valid got %0d expected %0d", validCount, v0); end
    checks++; if (data_out !== 8'h3C) begin errors++; $display("[TB] FAIL glitch_data_stable got %h expected 3c", data_out); end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = validCount;
    sendFrame(8'h00, 1'b0, 1'b1);
    sendFrame(8'hFF, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (validCount !== v0 + 2) begin errors++; $display("[TB] FAIL b2b_count got %0d expected %0d", validCount, v0 + 2); end
    checks++; if (prevData !== 8'h00) begin errors++; $display("[TB] FAIL b2b_first got %h expected 00", prevData); end
    checks++; if (lastData !== 8'hFF) begin errors++; $display("[TB] FAIL b2b_second got %h expected ff", lastData); end
    checks++; if (lastPe !== 1'b0) begin errors++; $display("[TB] FAIL b2b_pe got %b expected 0", lastPe); end
    checks++; if (lastFe !== 1'b0) begin errors++; $display("[TB] FAIL b2b_fe got %b expected 0", lastFe); end
    checks++; if (maxRun !== 1) begin errors++; $display("[TB] FAIL b2b_pulse_width got %0d expected 1", maxRun); end
  endtask

  task automatic test_reset_mid_frame;
    int v0;
    logic [4:0] partBits;
    v0 = validCount;
    partBits = 5'b00010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      serial_in = partBits[i];
      repeat (COUNTS_PER_BIT - 1) @(negedge clk);
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy_before got %b expected 1", busy); end
    @(negedge clk);
    rst = 1'b0;
    serial_in = 1'b1;
    @(negedge clk);
    checks++; if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL midrst_data got %h expected 00", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %b expected 0", busy); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got %b expected 0", data_valid); end
    checks++; if (parity_error !== 1'b0 || frame_error !== 1'b0) begin errors++; $display("[TB] FAIL midrst_flags got %b%b expected 00", parity_error, frame_error); end
    rst = 1'b1;
    repeat (2 * COUNTS_PER_BIT) @(negedge clk);
    checks++; if (validCount !== v0) begin errors++; $display("[TB] FAIL midrst_no_valid got %0d expected %0d", validCount, v0); end
    sendFrame(8'h81, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (validCount !== v0 + 1) begin errors++; $display("[TB] FAIL after_rst_count got %0d expected %0d", validCount, v0 + 1); end
    checks++; if (lastData !== 8'h81) begin errors++; $display("[TB] FAIL after_rst_data got %h expected 81", lastData); end
    checks++; if (lastPe !== 1'b0 || lastFe !== 1'b0) begin errors++; $display("[TB] FAIL after_rst_flags got %b%b expected 00", lastPe, lastFe); end
    checks++; if (lastValidCycle - frameStart !== VALID_LATENCY) begin errors++; $display("[TB] FAIL after_rst_latency got %0d expected %0d", lastValidCycle - frameStart, VALID_LATENCY); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
